// File: rtl/nibble_mayor_sched.sv
// Round-robin issue of 16-bit nibble words to a shared pipelined max datapath, with in-order tagged responses.
// Optional NM_SCHED_STATS_EN adds STAT_ISSUED / STAT_MAX counters.
//
// state      | meaning
// ST_IDLE    | nothing in flight, grants allowed
// ST_RUN     | ops issued or in flight, grants allowed
// ST_DRAIN   | grants blocked, waiting for datapath and response stage to empty
// ST_HALTED  | datapath empty, grants blocked until HALT drops
module nibble_mayor_sched #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int DP_LATENCY = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [16*NREQ-1:0]   REQ_NIBBLES,
  output logic [NREQ-1:0]      REQ_GNT,
  input  logic                 HALT,
  output logic                 HALTED,
  output logic                 BUSY,
  output logic                 DP_RESET_L,
  output logic                 DP_VALID,
  output logic [15:0]          DP_NIBBLES,
  input  logic [3:0]           DP_NIBBLE_MAYOR,
  output logic                 RSP_VALID,
  output logic [ID_W-1:0]      RSP_ID,
`ifdef NM_SCHED_STATS_EN
  output logic [15:0]          STAT_ISSUED,
  output logic [3:0]           STAT_MAX,
  output logic [3:0]           RSP_NIBBLE
`else
  output logic [3:0]           RSP_NIBBLE
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       dp_id;
  logic                  gnt_any;
  logic                  can_grant;
  logic                  in_flight;
  logic [DP_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]       tag_id [DP_LATENCY];

  assign DP_RESET_L = ~RESET;
  assign can_grant  = !RESET && !HALT && (state == ST_IDLE || state == ST_RUN);
  // Ops that will still be outstanding after this edge (current RSP stage excluded).
  assign in_flight  = DP_VALID || (|tag_v);

  always_comb begin
    REQ_GNT = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (can_grant) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_any && REQ_VALID[(int'(rr_ptr) + k) % NREQ]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'((int'(rr_ptr) + k) % NREQ);
        end
      end
    end
    if (gnt_any) REQ_GNT = NREQ'(1) << gnt_idx;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      dp_id      <= '0;
      DP_VALID   <= 1'b0;
      DP_NIBBLES <= '0;
      tag_v      <= '0;
      for (int i = 0; i < DP_LATENCY; i++) tag_id[i] <= '0;
      RSP_VALID  <= 1'b0;
      RSP_ID     <= '0;
      RSP_NIBBLE <= '0;
      BUSY       <= 1'b0;
      HALTED     <= 1'b0;
    end else begin
      DP_VALID <= gnt_any;
      if (gnt_any) begin
        DP_NIBBLES <= REQ_NIBBLES[16*int'(gnt_idx) +: 16];
        dp_id      <= gnt_idx;
        rr_ptr     <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end

      // Last tag stage lines up with the datapath result for that op.
      tag_v[0]  <= DP_VALID;
      tag_id[0] <= dp_id;
      for (int i = 1; i < DP_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      RSP_VALID <= tag_v[DP_LATENCY-1];
      if (tag_v[DP_LATENCY-1]) begin
        RSP_ID     <= tag_id[DP_LATENCY-1];
        RSP_NIBBLE <= DP_NIBBLE_MAYOR;
      end

      BUSY <= gnt_any || in_flight;

      case (state)
        ST_IDLE: begin
          if (HALT)         state <= ST_DRAIN;
          else if (gnt_any) state <= ST_RUN;
        end
        ST_RUN: begin
          if (HALT)                        state <= ST_DRAIN;
          else if (!gnt_any && !in_flight) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (!in_flight) begin
            state  <= ST_HALTED;
            HALTED <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!HALT) begin
            state  <= ST_IDLE;
            HALTED <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NM_SCHED_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      STAT_ISSUED <= '0;
      STAT_MAX    <= '0;
    end else begin
      if (gnt_any && STAT_ISSUED != 16'hFFFF) STAT_ISSUED <= STAT_ISSUED + 16'd1;
      if (RSP_VALID && RSP_NIBBLE > STAT_MAX) STAT_MAX <= RSP_NIBBLE;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_mayor_sched.sv
// Bench for nibble_mayor_sched: directed scenarios plus randomized traffic/HALT/RESET against a queue-based model.
module tb_nibble_mayor_sched;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int L    = 3;

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic [NREQ-1:0]     REQ_VALID = '0;
  logic [16*NREQ-1:0]  REQ_NIBBLES = '0;
  logic                HALT = 1'b0;
  logic [3:0]          DP_NIBBLE_MAYOR = '0;
  logic [NREQ-1:0]     REQ_GNT;
  logic                HALTED, BUSY, DP_RESET_L, DP_VALID, RSP_VALID;
  logic [15:0]         DP_NIBBLES;
  logic [ID_W-1:0]     RSP_ID;
  logic [3:0]          RSP_NIBBLE;
`ifdef NM_SCHED_STATS_EN
  logic [15:0]         STAT_ISSUED;
  logic [3:0]          STAT_MAX;
`endif

  nibble_mayor_sched #(.NREQ(NREQ), .ID_W(ID_W), .DP_LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_NIBBLES(REQ_NIBBLES),
    .REQ_GNT(REQ_GNT), .HALT(HALT), .HALTED(HALTED), .BUSY(BUSY),
    .DP_RESET_L(DP_RESET_L), .DP_VALID(DP_VALID), .DP_NIBBLES(DP_NIBBLES),
    .DP_NIBBLE_MAYOR(DP_NIBBLE_MAYOR), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID),
`ifdef NM_SCHED_STATS_EN
    .STAT_ISSUED(STAT_ISSUED), .STAT_MAX(STAT_MAX),
`endif
    .RSP_NIBBLE(RSP_NIBBLE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] maxnib(input logic [15:0] w);
    logic [3:0] m;
    m = 4'h0;
    for (int i = 0; i < 4; i++) if (w[4*i +: 4] > m) m = w[4*i +: 4];
    return m;
  endfunction

  // Model: outstanding ops as a queue with their response cycle; mode 0 run, 1 draining, 2 halted.
  typedef struct {
    int         due;
    int         id;
    logic [3:0] nib;
  } op_t;

  op_t         q[$];
  int          ptr = 0;
  int          mode = 0;
  bit          prev_g = 1'b0;
  logic [15:0] exp_dp = '0;
  int          mdl_gnt = -1;
  bit          chk_on = 1'b0;
  int          st_iss = 0;
  logic [3:0]  st_max = '0;
  logic        hv [8];
  logic [15:0] hd [8];

  always @(negedge CLK) begin : model
    int         g;
    bit         erv;
    op_t        op;
    logic [3:0] rnib;
    cyc++;
    g = -1;
    if (!RESET && mode == 0 && !HALT)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && REQ_VALID[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    erv  = (q.size() != 0) && (q[0].due == cyc);
    rnib = erv ? q[0].nib : 4'h0;
    if (chk_on) begin
      check("gnt",        32'(REQ_GNT), (g >= 0) ? (32'd1 << g) : 32'd0);
      check("dp_valid",   32'(DP_VALID), 32'(prev_g));
      check("dp_nibbles", 32'(DP_NIBBLES), 32'(exp_dp));
      check("busy",       32'(BUSY), 32'(q.size() != 0));
      check("halted",     32'(HALTED), 32'(mode == 2));
      check("dp_reset_l", 32'(DP_RESET_L), 32'(!RESET));
      check("rsp_valid",  32'(RSP_VALID), 32'(erv));
      if (erv) begin
        check("rsp_id",     32'(RSP_ID), 32'(q[0].id));
        check("rsp_nibble", 32'(RSP_NIBBLE), 32'(q[0].nib));
      end
`ifdef NM_SCHED_STATS_EN
      check("stat_issued", 32'(STAT_ISSUED), (st_iss > 65535) ? 32'd65535 : 32'(st_iss));
      check("stat_max",    32'(STAT_MAX), 32'(st_max));
`endif
    end
    if (erv) void'(q.pop_front());

    // Datapath stand-in: result appears L cycles after DP_VALID, garbage otherwise.
    hv[cyc % 8] = DP_VALID;
    hd[cyc % 8] = DP_NIBBLES;
    DP_NIBBLE_MAYOR = (cyc > L && hv[(cyc - L) % 8] === 1'b1) ? maxnib(hd[(cyc - L) % 8]) : 4'($urandom);

    mdl_gnt = g;
    if (RESET) begin
      q.delete();
      ptr = 0; mode = 0; prev_g = 1'b0; exp_dp = '0;
      st_iss = 0; st_max = '0;
    end else begin
      if (erv && rnib > st_max) st_max = rnib;
      prev_g = (g >= 0);
      if (g >= 0) begin
        op.due = cyc + L + 2;
        op.id  = g;
        op.nib = maxnib(REQ_NIBBLES[16*g +: 16]);
        q.push_back(op);
        exp_dp = REQ_NIBBLES[16*g +: 16];
        ptr = (g + 1) % NREQ;
        st_iss++;
      end
      case (mode)
        0: if (HALT) mode = 1;
        1: if (q.size() == 0) mode = 2;
        2: if (!HALT) mode = 0;
        default: mode = 0;
      endcase
    end
  end

  int load = 40;
  int halt_cnt = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin hv[i] = 1'b0; hd[i] = '0; end
    @(posedge CLK); #1 chk_on = 1'b1;
    repeat (2) @(posedge CLK);

    // Single op: grant c0, DP_VALID c1, response c5 with max nibble A
    #1 RESET = 1'b0; REQ_VALID = 4'b0001; REQ_NIBBLES[15:0] = 16'h3A51;
    @(negedge CLK) check("t1_gnt", 32'(REQ_GNT), 32'h1);
    @(posedge CLK); #1 REQ_VALID = '0;
    @(negedge CLK);
    check("t1_dp_valid", 32'(DP_VALID), 32'h1);
    check("t1_dp_nibbles", 32'(DP_NIBBLES), 32'h3A51);
    repeat (3) @(negedge CLK);
    check("t1_rsp_early", 32'(RSP_VALID), 32'h0);
    @(negedge CLK);
    check("t1_rsp_valid", 32'(RSP_VALID), 32'h1);
    check("t1_rsp_id", 32'(RSP_ID), 32'h0);
    check("t1_rsp_nibble", 32'(RSP_NIBBLE), 32'hA);

    // Pointer skip: pointer=1, requests 1001 -> grant 3 then 0
    @(posedge CLK); #1 REQ_VALID = 4'b1001; REQ_NIBBLES = {16'h1234, 16'h0, 16'h0, 16'h8F00};
    @(negedge CLK) check("t3_gnt_first", 32'(REQ_GNT), 32'h8);
    @(posedge CLK); #1 REQ_VALID = 4'b0001;
    @(negedge CLK) check("t3_gnt_second", 32'(REQ_GNT), 32'h1);
    @(posedge CLK); #1 REQ_VALID = '0;
    repeat (8) @(posedge CLK);

    // Drain: three grants (1,2,3), then HALT
    #1 REQ_VALID = 4'hF; REQ_NIBBLES = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK) check("t4_gnt_rr", 32'(REQ_GNT), 32'h2 << i);
      @(posedge CLK); #1;
    end
    HALT = 1'b1;
    for (int i = 3; i < 8; i++) begin
      @(negedge CLK) check("t4_gnt_blocked", 32'(REQ_GNT), 32'h0);
      if (i == 7) begin
        check("t4_last_rsp", 32'(RSP_VALID), 32'h1);
        check("t4_not_yet_halted", 32'(HALTED), 32'h0);
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK) check("t4_halted", 32'(HALTED), 32'h1);
    @(posedge CLK); #1 HALT = 1'b0;
    @(negedge CLK) check("t4_gnt_halted_cycle", 32'(REQ_GNT), 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK) check("t4_gnt_resume", 32'(REQ_GNT), 32'h1);

    // Reset with two ops in flight
    @(posedge CLK); #1;
    @(posedge CLK); #1 REQ_VALID = '0; RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    check("t5_dp_valid", 32'(DP_VALID), 32'h0);
    check("t5_dp_nibbles", 32'(DP_NIBBLES), 32'h0);
    check("t5_rsp_valid", 32'(RSP_VALID), 32'h0);
    check("t5_rsp_id", 32'(RSP_ID), 32'h0);
    check("t5_rsp_nibble", 32'(RSP_NIBBLE), 32'h0);
    check("t5_busy", 32'(BUSY), 32'h0);
    check("t5_halted", 32'(HALTED), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK) check("t5_no_rsp", 32'(RSP_VALID), 32'h0);
    end

    // Randomized traffic with HALT episodes and occasional RESET
    for (int n = 0; n < 4000; n++) begin
      @(posedge CLK); #1;
      if (n % 500 == 0) load = $urandom_range(10, 100);
      if (mdl_gnt >= 0) REQ_VALID[mdl_gnt] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (!REQ_VALID[i] && $urandom_range(0, 99) < load) begin
          REQ_VALID[i] = 1'b1;
          REQ_NIBBLES[16*i +: 16] = 16'($urandom);
        end
      if (halt_cnt > 0) begin
        halt_cnt--;
        HALT = 1'b1;
      end else begin
        HALT = 1'b0;
        if ($urandom_range(0, 99) == 0) halt_cnt = $urandom_range(1, 25);
      end
      RESET = ($urandom_range(0, 299) == 0);
    end
    @(posedge CLK); #1 RESET = 1'b0; REQ_VALID = '0; HALT = 1'b0;
    repeat (12) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
